// File: rtl/mixcolumn_module.sv
// AES MixColumns stage: latches four columns on start, emits one mixed column per clock.
// Latency: 4 CALC cycles, so done rises 5 edges after start is first sampled; no backpressure, and done holds while start stays high.
module mixcolumn_module (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] statew1,
  input  logic [31:0] statew2,
  input  logic [31:0] statew3,
  input  logic [31:0] statew4,
  output logic        done,
  output logic [31:0] new_statew1,
  output logic [31:0] new_statew2,
  output logic [31:0] new_statew3,
  output logic [31:0] new_statew4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       col;
  logic [3:0][31:0] lat;
  logic [3:0][31:0] res;
  logic             load;
  logic             calc;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    // 3x is expressed as xtime(x)^x
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    mix_col = {b0, b1, b2, b3};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (col == 2'd3) state_next = FIN;
      FIN:     if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    calc = 1'b0;
    done = 1'b0;
    case (state)
      IDLE:    load = start;
      CALC:    calc = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // Results persist through IDLE; they are only overwritten column by column in CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat <= '0;
      res <= '0;
      col <= 2'd0;
    end else if (load) begin
      lat <= {statew4, statew3, statew2, statew1};
      col <= 2'd0;
    end else if (calc) begin
      res[col] <= mix_col(lat[col]);
      col      <= col + 2'd1;
    end
  end

  assign new_statew1 = res[0];
  assign new_statew2 = res[1];
  assign new_statew3 = res[2];
  assign new_statew4 = res[3];

endmodule

// File: tb/tb_mixcolumn_module.sv
// Self-checking bench for mixcolumn_module: directed vectors plus random columns
// compared against a generic GF(2^8) matrix-multiply model.
module tb_mixcolumn_module;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] statew1, statew2, statew3, statew4;
  logic        done;
  logic [31:0] new_statew1, new_statew2, new_statew3, new_statew4;

  int checks;
  int failures;
  logic [3:0][31:0] exp_out;

  mixcolumn_module dut (
    .clk(clk), .rst(rst), .start(start),
    .statew1(statew1), .statew2(statew2), .statew3(statew3), .statew4(statew4),
    .done(done),
    .new_statew1(new_statew1), .new_statew2(new_statew2),
    .new_statew3(new_statew3), .new_statew4(new_statew4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift-and-add GF(2^8) multiply, reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] w);
    logic [7:0] coef [4];
    logic [7:0] a [4];
    logic [7:0] r;
    logic [31:0] out;
    coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
    for (int c = 0; c < 4; c++) a[c] = w[31-8*c -: 8];
    out = '0;
    for (int row = 0; row < 4; row++) begin
      r = 8'h00;
      for (int c = 0; c < 4; c++) r = r ^ gmul(a[c], coef[(c - row + 4) % 4]);
      out[31-8*row -: 8] = r;
    end
    return out;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".w1"}, new_statew1, exp_out[0]);
    check({tag, ".w2"}, new_statew2, exp_out[1]);
    check({tag, ".w3"}, new_statew3, exp_out[2]);
    check({tag, ".w4"}, new_statew4, exp_out[3]);
  endtask

  task automatic apply(input logic [3:0][31:0] d);
    statew1 = d[0]; statew2 = d[1]; statew3 = d[2]; statew4 = d[3];
  endtask

  // Starts an operation from IDLE and checks column order and done timing; leaves start high.
  task automatic run_op(input logic [3:0][31:0] d, input string tag);
    apply(d);
    start = 1'b1;
    step();
    check({tag, ".done_e1"}, {31'd0, done}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_out[k-1] = model_col(d[k-1]);
      check_outs($sformatf("%s.e%0d", tag, k + 1));
      check($sformatf("%s.done_e%0d", tag, k + 1), {31'd0, done}, (k == 4) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    logic [3:0][31:0] d;
    checks = 0;
    failures = 0;
    exp_out = '0;
    rst = 1'b1;
    start = 1'b0;
    d = '0;
    apply(d);

    // Reset and idle behaviour
    step();
    step();
    check("rst.done", {31'd0, done}, 32'd0);
    check_outs("rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle.done", {31'd0, done}, 32'd0);
    end

    // Minimal vector, start held through DONE
    d = {4{32'h00000001}};
    run_op(d, "ones");
    check("ones.const", new_statew3, 32'h01010302);
    for (int i = 0; i < 3; i++) begin
      apply({32'h12345678, 32'h9abcdef0, 32'hdeadbeef, 32'hcafef00d});
      step();
      check("ones.hold_done", {31'd0, done}, 32'd1);
      check_outs("ones.hold");
    end
    start = 1'b0;
    step();
    check("ones.drop", {31'd0, done}, 32'd0);
    check_outs("ones.idle_hold");

    // Known vectors, one per column
    d = {32'hc6c6c6c6, 32'h01010101, 32'hf20a225c, 32'hdb135345};
    run_op(d, "known");
    check("known.w1", new_statew1, 32'h8e4da1bc);
    check("known.w2", new_statew2, 32'h9fdc589d);
    check("known.w3", new_statew3, 32'h01010101);
    check("known.w4", new_statew4, 32'hc6c6c6c6);
    start = 1'b0;
    step();

    // Inputs changed during CALC must not affect the result
    apply({4{32'hd4bf5d30}});
    start = 1'b1;
    step();
    step();
    apply({$urandom, $urandom, $urandom, $urandom});
    step();
    step();
    step();
    check("ign.done", {31'd0, done}, 32'd1);
    check("ign.w1", new_statew1, 32'h046681e5);
    check("ign.w2", new_statew2, 32'h046681e5);
    check("ign.w3", new_statew3, 32'h046681e5);
    check("ign.w4", new_statew4, 32'h046681e5);
    exp_out = {4{32'h046681e5}};
    start = 1'b0;
    step();
    check("ign.drop", {31'd0, done}, 32'd0);

    // Reset during CALC aborts, then a fresh operation completes
    d = {$urandom, $urandom, $urandom, $urandom};
    apply(d);
    start = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    exp_out = '0;
    check("abort.done", {31'd0, done}, 32'd0);
    check_outs("abort");
    step();
    check("abort.idle", {31'd0, done}, 32'd0);
    d = {$urandom, $urandom, $urandom, $urandom};
    run_op(d, "restart");
    start = 1'b0;
    step();

    // Reset and start in the same cycle: reset wins, no operation starts
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    exp_out = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rst_start.done", {31'd0, done}, 32'd0);
    end
    check_outs("rst_start");

    // Random operations
    for (int n = 0; n < 12; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_op(d, $sformatf("rnd%0d", n));
      start = 1'b0;
      step();
      check($sformatf("rnd%0d.drop", n), {31'd0, done}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
